// File: rtl/morra_pkg.sv
// Shared types for the rock-paper-scissors match controller.
// Moves, round/match results, FSM states and the "beats" rule.
package morra_pkg;

    typedef enum logic [1:0] {
        MV_NONE     = 2'b00,
        MV_ROCK     = 2'b01,
        MV_PAPER    = 2'b10,
        MV_SCISSORS = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_DRAW = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // True when move a beats move b.
    function automatic logic beats(input move_t a, input move_t b);
        logic r;
        r = 1'b0;
        unique case (1'b1)
            (a == MV_ROCK     && b == MV_SCISSORS),
            (a == MV_SCISSORS && b == MV_PAPER),
            (a == MV_PAPER    && b == MV_ROCK): r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morra_round_judge.sv
// Combinational round judge: decides one round from both moves
// and the current blocked player/move pair.
module morra_round_judge
    import morra_pkg::*;
(
    input  move_t   g1_i,
    input  move_t   g2_i,
    input  result_t blk_pl_i,
    input  move_t   blk_mv_i,
    output result_t res_o,
    output logic    counted_o,
    output move_t   win_mv_o
);

    logic p1_wins;
    logic p2_wins;

    assign p1_wins = beats(g1_i, g2_i);
    assign p2_wins = beats(g2_i, g1_i);

    // Missing move, draw, or a win that may be vetoed by the block rule.
    always_comb begin
        res_o     = RES_NONE;
        counted_o = 1'b0;
        win_mv_o  = MV_NONE;
        if (g1_i == MV_NONE || g2_i == MV_NONE) begin
            res_o = RES_NONE;
        end else if (g1_i == g2_i) begin
            res_o     = RES_DRAW;
            counted_o = 1'b1;
        end else if (p1_wins) begin
            if (blk_pl_i == RES_P1 && blk_mv_i == g1_i) begin
                res_o = RES_NONE;
            end else begin
                res_o     = RES_P1;
                counted_o = 1'b1;
                win_mv_o  = g1_i;
            end
        end else if (p2_wins) begin
            if (blk_pl_i == RES_P2 && blk_mv_i == g2_i) begin
                res_o = RES_NONE;
            end else begin
                res_o     = RES_P2;
                counted_o = 1'b1;
                win_mv_o  = g2_i;
            end
        end
    end

endmodule

// File: rtl/morra_match_ctrl.sv
// Two-player rock-paper-scissors match controller: FSM, scores,
// round counter, block register and end-of-match decision.
module morra_match_ctrl
    import morra_pkg::*;
#(
    parameter int MIN_ROUNDS = 4,
    parameter int LEAD_WIN   = 2,
    parameter int EXTRA_W    = 4,
    parameter int CNT_W      = 5
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [EXTRA_W-1:0] cfg_extra,
    input  logic [1:0]         g1,
    input  logic [1:0]         g2,
    output logic [1:0]         manche,
    output logic [1:0]         partita,
    output logic               busy,
    output logic [CNT_W-1:0]   round_cnt,
    output logic [CNT_W-1:0]   score1,
    output logic [CNT_W-1:0]   score2
);

    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_ROUNDS);
    localparam logic signed [CNT_W:0] LEAD_C = (CNT_W+1)'(LEAD_WIN);

    state_t            state_q;
    logic [CNT_W-1:0]  max_q;
    logic [CNT_W-1:0]  rnd_q, rnd_d;
    logic [CNT_W-1:0]  s1_q, s1_d;
    logic [CNT_W-1:0]  s2_q, s2_d;
    result_t           blk_pl_q, blk_pl_d;
    move_t             blk_mv_q, blk_mv_d;
    result_t           manche_q;
    result_t           partita_q;
    logic              busy_q;

    result_t           judge_res;
    logic              judge_cnt;
    move_t             judge_mv;

    logic signed [CNT_W:0] lead_d;
    logic              lead_end;
    logic              max_end;
    logic              match_end;
    result_t           end_res;

    morra_round_judge u_judge (
        .g1_i      (move_t'(g1)),
        .g2_i      (move_t'(g2)),
        .blk_pl_i  (blk_pl_q),
        .blk_mv_i  (blk_mv_q),
        .res_o     (judge_res),
        .counted_o (judge_cnt),
        .win_mv_o  (judge_mv)
    );

    // Counter/score/block updates for a counted round and the end check.
    always_comb begin
        rnd_d    = rnd_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        blk_pl_d = blk_pl_q;
        blk_mv_d = blk_mv_q;
        if (judge_cnt) begin
            rnd_d = rnd_q + CNT_W'(1);
            if (judge_res == RES_P1) begin
                s1_d = s1_q + CNT_W'(1);
            end
            if (judge_res == RES_P2) begin
                s2_d = s2_q + CNT_W'(1);
            end
            if (judge_res == RES_DRAW) begin
                blk_pl_d = RES_NONE;
                blk_mv_d = MV_NONE;
            end else begin
                blk_pl_d = judge_res;
                blk_mv_d = judge_mv;
            end
        end

        lead_d   = $signed({1'b0, s1_d}) - $signed({1'b0, s2_d});
        lead_end = (rnd_d >= MIN_C) &&
                   ((lead_d >= LEAD_C) || (lead_d <= -LEAD_C));
        max_end  = (rnd_d == max_q);
        match_end = judge_cnt && (lead_end || max_end);

        if (lead_d[CNT_W]) begin
            end_res = RES_P2;
        end else if (lead_d == '0) begin
            end_res = RES_DRAW;
        end else begin
            end_res = RES_P1;
        end
    end

    // Match FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            max_q     <= MIN_C;
            rnd_q     <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            blk_pl_q  <= RES_NONE;
            blk_mv_q  <= MV_NONE;
            manche_q  <= RES_NONE;
            partita_q <= RES_NONE;
            busy_q    <= 1'b0;
        end else if (start) begin
            state_q   <= ST_PLAY;
            max_q     <= MIN_C + CNT_W'(cfg_extra);
            rnd_q     <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            blk_pl_q  <= RES_NONE;
            blk_mv_q  <= MV_NONE;
            manche_q  <= RES_NONE;
            partita_q <= RES_NONE;
            busy_q    <= 1'b1;
        end else begin
            unique case (state_q)
                ST_PLAY: begin
                    manche_q <= judge_res;
                    rnd_q    <= rnd_d;
                    s1_q     <= s1_d;
                    s2_q     <= s2_d;
                    blk_pl_q <= blk_pl_d;
                    blk_mv_q <= blk_mv_d;
                    if (match_end) begin
                        partita_q <= end_res;
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    manche_q <= RES_NONE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    manche_q <= RES_NONE;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign manche    = manche_q;
    assign partita   = partita_q;
    assign busy      = busy_q;
    assign round_cnt = rnd_q;
    assign score1    = s1_q;
    assign score2    = s2_q;

endmodule
